// File: rtl/mem_responder_if.sv
// Request/response channels between the CPU core (master) and the memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave with programmable wait states, one request in flight,
// read-before-write stores and out-of-range flagging.
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;

  logic [31:0] mem [DEPTH];
  logic        in_range;
  logic        do_access;
  logic [AW-1:0] mem_idx;

  // Full 32-bit compare so high address bits never alias into the array.
  assign in_range  = (addr_q < 32'(DEPTH));
  assign mem_idx   = addr_q[AW-1:0];
  assign do_access = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = in_range ? mem[mem_idx] : 32'd0;
          err_d   = ~in_range;
          valid_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (do_access && we_q && in_range) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q == StWait) || (state_q == StResp);
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance for the functional scenarios and a
// LATENCY=0 instance for back-to-back spacing.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    bit          chk;
  } step_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  mem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request on bus A, returns edges from acceptance to resp_valid, then handshakes.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_a.resp_valid && lat < 40);
    rdata = bus_a.resp_rdata;
    err   = bus_a.resp_err;
    @(negedge clk);
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_cmp++;
    if ({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err, bus_a.busy} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
               bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err, bus_a.busy);
    end
    n_cmp++;
    if ({bus_b.req_ready, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err, bus_b.busy} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_b: rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
               bus_b.req_ready, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err, bus_b.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_table(input string name, input step_t tbl[$]);
    int lat;
    logic [31:0] rdata;
    logic err;
    exp_t e;
    foreach (tbl[i]) begin
      sb.push_back('{rdata: tbl[i].rdata, err: tbl[i].err, chk: tbl[i].chk});
      run_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rdata, err);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 3) begin
        n_bad++;
        $display("FAIL %s[%0d] latency: got %0d edges, want 3", name, i, lat);
      end
      n_cmp++;
      if (err !== e.err || (e.chk && rdata !== e.rdata)) begin
        n_bad++;
        $display("FAIL %s[%0d] resp: got rdata=%h err=%b, want rdata=%h err=%b (chk=%0d)",
                 name, i, rdata, err, e.rdata, e.err, e.chk);
      end
    end
  endtask

  task automatic test_store_load();
    step_t tbl[$];
    tbl = '{'{1'b1, 32'd5, 32'h0000_0000, 32'd0, 1'b0, 1'b0},
            '{1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1},
            '{1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1}};
    run_table("store_load", tbl);
  endtask

  task automatic test_out_of_range();
    step_t tbl[$];
    tbl = '{'{1'b1, 32'd0, 32'h0000_00AA, 32'd0, 1'b0, 1'b0},
            '{1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, 1'b1},
            '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1},
            '{1'b0, 32'd0, 32'd0, 32'h0000_00AA, 1'b0, 1'b1},
            '{1'b1, 32'd1023, 32'h1234_5678, 32'd0, 1'b0, 1'b0},
            '{1'b0, 32'd1023, 32'd0, 32'h1234_5678, 1'b0, 1'b1},
            '{1'b0, 32'h0001_0005, 32'd0, 32'd0, 1'b1, 1'b1}};
    run_table("out_of_range", tbl);
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    step_t tbl[$];
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, chk: 1'b1});
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b0;
    bus_a.req_addr  = 32'd5;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_a.resp_valid && lat < 40);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 3 || bus_a.resp_rdata !== e.rdata || bus_a.resp_err !== e.err) begin
      n_bad++;
      $display("FAIL bp_first: lat=%0d rdata=%h err=%b, want 3 %h %b",
               lat, bus_a.resp_rdata, bus_a.resp_err, e.rdata, e.err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!bus_a.resp_valid || bus_a.req_ready || bus_a.resp_rdata !== e.rdata ||
          bus_a.resp_err !== e.err) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b rdata=%h err=%b, want 1 0 %h %b", i,
                 bus_a.resp_valid, bus_a.req_ready, bus_a.resp_rdata, bus_a.resp_err,
                 e.rdata, e.err);
      end
      if (i == 1) begin
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = 1'b1;
        bus_a.req_addr  = 32'd5;
        bus_a.req_wdata = 32'h1234_5678;
      end else begin
        bus_a.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
    n_cmp++;
    if (bus_a.req_ready !== 1'b1 || bus_a.resp_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: rdy=%b vld=%b busy=%b, want 1 0 0",
               bus_a.req_ready, bus_a.resp_valid, bus_a.busy);
    end
    tbl = '{'{1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1}};
    run_table("bp_after", tbl);
  endtask

  task automatic test_reset_midop();
    step_t tbl[$];
    tbl = '{'{1'b1, 32'd7, 32'h0000_0001, 32'd0, 1'b0, 1'b0},
            '{1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1}};
    run_table("midop_setup", tbl);
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'd7;
    bus_a.req_wdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    n_cmp++;
    if (bus_a.busy !== 1'b1 || bus_a.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_wait: busy=%b rdy=%b, want 1 0", bus_a.busy, bus_a.req_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err, bus_a.busy} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midop_async: rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
               bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err, bus_a.busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tbl = '{'{1'b0, 32'd7, 32'd0, 32'h0000_0001, 1'b0, 1'b1}};
    run_table("midop_after", tbl);
  endtask

  task automatic test_back_to_back();
    step_t tbl[$];
    exp_t e;
    int k = 0;
    int got = 0;
    int last_acc = -10;
    tbl = '{'{1'b1, 32'd3, 32'hA5A5_0003, 32'd0, 1'b0, 1'b0},
            '{1'b0, 32'd3, 32'd0, 32'hA5A5_0003, 1'b0, 1'b1},
            '{1'b0, 32'd4000, 32'd0, 32'd0, 1'b1, 1'b1},
            '{1'b1, 32'd3, 32'h0000_0033, 32'hA5A5_0003, 1'b0, 1'b1},
            '{1'b0, 32'd3, 32'd0, 32'h0000_0033, 1'b0, 1'b1}};
    bus_b.resp_ready = 1'b1;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_b.resp_valid && bus_b.req_ready) begin
        n_bad++;
        $display("FAIL b2b_exclusive: resp_valid=1 req_ready=1 at cycle %0d, want not both", cyc);
      end
      if (bus_b.resp_valid) begin
        got++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_spurious: response at cycle %0d, want none pending", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != last_acc + 1 || bus_b.resp_err !== e.err ||
              (e.chk && bus_b.resp_rdata !== e.rdata)) begin
            n_bad++;
            $display("FAIL b2b_resp: edge=%0d rdata=%h err=%b, want edge=%0d rdata=%h err=%b",
                     cyc, bus_b.resp_rdata, bus_b.resp_err, last_acc + 1, e.rdata, e.err);
          end
        end
      end
      if (bus_b.req_ready && k < 5) begin
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = tbl[k].we;
        bus_b.req_addr  = tbl[k].addr;
        bus_b.req_wdata = tbl[k].wdata;
        sb.push_back('{rdata: tbl[k].rdata, err: tbl[k].err, chk: tbl[k].chk});
        if (k > 0) begin
          n_cmp++;
          if (cyc + 1 - last_acc != 3) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d]: got %0d edges, want 3", k, cyc + 1 - last_acc);
          end
        end
        last_acc = cyc + 1;
        k++;
      end else if (k >= 5) begin
        bus_b.req_valid = 1'b0;
      end
    end
    bus_b.req_valid  = 1'b0;
    bus_b.resp_ready = 1'b0;
    n_cmp++;
    if (got != 5) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d responses, want 5", got);
    end
    sb.delete();
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
